// File: rtl/parametric_serial_subtractor_pkg.sv
// ============================================================================
// Module  : parametric_arith_pkg
// Brief   : Shared state encoding and sizing helpers for serial arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package parametric_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } serial_state_t;

    // Bit-index counter width; a 1-bit counter is the floor for tiny widths.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/parametric_serial_subtractor_fs.sv
// ============================================================================
// Module  : full_subtractor
// Brief   : Combinational 1-bit full subtractor, d = x - y - bin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/parametric_serial_subtractor.sv
// ============================================================================
// Module  : parametric_serial_subtractor
// Brief   : Bit-serial unsigned subtractor, LSB first, start/busy/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parametric_serial_subtractor
    import parametric_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    serial_state_t    r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + CW'(1);
                    // Only the final bit publishes; diff never shows partial results.
                    if (w_last) begin
                        r_state <= S_DONE;
                        diff    <= w_res_next;
                        borrow  <= w_bout;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_parametric_serial_subtractor.sv
// ============================================================================
// Module  : tb_parametric_serial_subtractor
// Brief   : Self-checking bench for the serial subtractor, WIDTH=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parametric_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks;
    int failures;

    parametric_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic and unsigned compare.
    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned m;
        m = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
        return m[WIDTH-1:0];
    endfunction

    function automatic logic ref_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return int'(x) < int'(y);
    endfunction

    logic [WIDTH-1:0] held_diff;
    logic             held_borrow;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: busy=%0b done=%0b diff=%0d borrow=%0b required all 0", busy, done, diff, borrow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
                failures++;
                $display("FAIL idle_quiet cyc %0d: busy=%0b done=%0b diff=%0d borrow=%0b required all 0", k, busy, done, diff, borrow);
            end
        end
        held_diff   = '0;
        held_borrow = 1'b0;
    endtask

    // One full operation; optionally re-pulses start during RUN and DONE.
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input bit inject);
        int ndone;
        int done_k;
        logic [WIDTH-1:0] ed;
        logic             eb;
        ed = ref_diff(xa, xb);
        eb = ref_borrow(xa, xb);
        ndone  = 0;
        done_k = -1;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL accept_busy: busy=%0b required 1", busy);
        end
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                done_k = k;
            end
            checks++;
            if (busy !== (k <= WIDTH)) begin
                failures++;
                $display("FAIL busy_window k=%0d: busy=%0b required %0b", k, busy, (k <= WIDTH));
            end
            if (k < WIDTH) begin
                checks++;
                if (diff !== held_diff || borrow !== held_borrow) begin
                    failures++;
                    $display("FAIL hold_prev k=%0d: diff=%0d borrow=%0b required %0d/%0b", k, diff, borrow, held_diff, held_borrow);
                end
            end
            if (inject) begin
                if (k == 3) begin
                    start = 1'b1; a = 8'd5; b = 8'd3;
                end
                if (k == 4) start = 1'b0;
                if (k == WIDTH) begin
                    start = 1'b1; a = 8'd5; b = 8'd3;
                end
                if (k == WIDTH + 1) start = 1'b0;
            end
        end
        checks++;
        if (ndone != 1 || done_k != WIDTH) begin
            failures++;
            $display("FAIL done_pulse a=%0d b=%0d: count=%0d at_edge=%0d required 1 at %0d", xa, xb, ndone, done_k, WIDTH);
        end
        checks++;
        if (diff !== ed || borrow !== eb) begin
            failures++;
            $display("FAIL result a=%0d b=%0d: diff=%0d borrow=%0b required %0d/%0b", xa, xb, diff, borrow, ed, eb);
        end
        held_diff   = ed;
        held_borrow = eb;
    endtask

    task automatic test_directed();
        run_op(8'd20, 8'd10, 1'b0);
        run_op(8'd10, 8'd20, 1'b0);
        run_op(8'd0, 8'd1, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    endtask

    task automatic test_ignore_busy();
        run_op(8'd255, 8'd1, 1'b1);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a = 8'd100;
        b = 8'd50;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL abort_async: busy=%0b done=%0b diff=%0d borrow=%0b required all 0", busy, done, diff, borrow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, diff, borrow} !== {1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0}) begin
                failures++;
                $display("FAIL abort_quiet k=%0d: busy=%0b done=%0b diff=%0d borrow=%0b required all 0", k, busy, done, diff, borrow);
            end
        end
        held_diff   = '0;
        held_borrow = 1'b0;
        run_op(8'd100, 8'd50, 1'b0);
    endtask

    // start high through reset release and beyond: back-to-back acceptances.
    task automatic test_back_to_back();
        int last_acc;
        int nacc;
        int ndone;
        logic prev_busy;
        @(negedge clk);
        rst_n = 1'b0;
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        prev_busy = 1'b0;
        last_acc = -1;
        nacc = 0;
        ndone = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL first_edge_accept: busy=%0b required 1", busy);
                end
            end
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                if (nacc > 0) begin
                    checks++;
                    if (k - last_acc != WIDTH + 2) begin
                        failures++;
                        $display("FAIL accept_interval: got %0d cycles required %0d", k - last_acc, WIDTH + 2);
                    end
                end
                nacc++;
                last_acc = k;
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (diff !== ref_diff(8'd7, 8'd9) || borrow !== ref_borrow(8'd7, 8'd9)) begin
                    failures++;
                    $display("FAIL b2b_result: diff=%0d borrow=%0b required %0d/%0b", diff, borrow, ref_diff(8'd7, 8'd9), ref_borrow(8'd7, 8'd9));
                end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        checks++;
        if (nacc != 5 || ndone != 4) begin
            failures++;
            $display("FAIL b2b_counts: accepts=%0d dones=%0d required 5/4", nacc, ndone);
        end
        repeat (WIDTH + 3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: busy=%0b required 0", busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
